// File: rtl/perf_pkg.sv
// Shared definitions for the Wishbone latency probe: register offsets, CTRL bits,
// probe FSM states and the log2 histogram binning helper.
package perf_pkg;

    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_COUNT = 4'd1;
    localparam logic [3:0] REG_TOTAL = 4'd2;
    localparam logic [3:0] REG_MIN   = 4'd3;
    localparam logic [3:0] REG_MAX   = 4'd4;
    localparam logic [3:0] REG_LAST  = 4'd5;
    localparam logic [3:0] REG_ABORT = 4'd6;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic {
        IDLE,
        BUSY
    } probe_state_t;

    // floor(log2 lat) clamped to bin 7; a latency of 0 never occurs.
    function automatic logic [2:0] hist_bin(input logic [31:0] lat);
        logic [2:0] bin;
        bin = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (lat >= (32'd1 << k)) bin = 3'(k);
        end
        return bin;
    endfunction

endpackage

// File: rtl/lat_hist.sv
// Eight wrapping 32-bit histogram bins indexed by floor(log2 latency).
// Only compiled when WB_LAT_PROBE_HIST_EN is defined.
`ifdef WB_LAT_PROBE_HIST_EN
module lat_hist
    import perf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        done,
    input  logic [31:0] lat,
    input  logic [2:0]  sel,
    output logic [31:0] bin_q
);

    logic [31:0] bins [8];
    logic [2:0]  bin_idx;

    assign bin_idx = hist_bin(lat);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < 8; k++) bins[k] <= '0;
        end else if (done) begin
            bins[bin_idx] <= bins[bin_idx] + 32'd1;
        end
    end

    assign bin_q = bins[sel];

endmodule
`endif

// File: rtl/wb_lat_probe.sv
// Passive per-access latency probe on a monitored Wishbone master, with a slave
// register window for statistics. Define WB_LAT_PROBE_HIST_EN to add the histogram.
module wb_lat_probe
    import perf_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h9900_0020,
    parameter int          LAT_W    = 16,
    parameter int          TOT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_o,
    input  logic        wb_we,
    input  logic        wb_stb,
    output logic [31:0] wb_dat_i,
    output logic        wb_ack,
    output logic        wb_rty,
    output logic        wb_err,
    input  logic        mon_cyc,
    input  logic        mon_stb,
    input  logic        mon_ack
);

`ifdef WB_LAT_PROBE_HIST_EN
    localparam logic [31:0] WIN_BYTES = 32'd64;
`else
    localparam logic [31:0] WIN_BYTES = 32'd32;
`endif

    probe_state_t       state, state_nxt;
    logic [LAT_W-1:0]   lat, lat_nxt, done_lat;
    logic               done, abort_evt;

    logic               en;
    logic [31:0]        count, aborts, min_q;
    logic [TOT_W-1:0]   total;
    logic [TOT_W:0]     tot_sum;
    logic [LAT_W-1:0]   max_q, last_q;

    logic [31:0]        adr_off, rd_data;
    logic [3:0]         word;
    logic               access, wr_ctrl, clr;
    logic               unused_dat;

    assign wb_rty = 1'b0;
    assign wb_err = 1'b0;

    // Ack is forced low for the cycle after an ack so a held strobe gets one ack per transfer.
    assign adr_off = wb_adr - BASE_ADR;
    assign word    = adr_off[5:2];
    assign access  = wb_stb && !wb_ack && (wb_adr >= BASE_ADR) && (adr_off < WIN_BYTES);
    assign wr_ctrl = access && wb_we && (word == REG_CTRL);
    assign clr     = wr_ctrl && wb_dat_o[CTRL_CLR_BIT];
    assign unused_dat = &{1'b0, wb_dat_o[31:2]};

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        done      = 1'b0;
        done_lat  = '0;
        abort_evt = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            lat_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mon_cyc && mon_stb) begin
                        if (mon_ack) begin
                            done     = 1'b1;
                            done_lat = LAT_W'(1);
                        end else begin
                            state_nxt = BUSY;
                            lat_nxt   = LAT_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (!mon_cyc) begin
                        abort_evt = 1'b1;
                        state_nxt = IDLE;
                        lat_nxt   = '0;
                    end else if (mon_ack) begin
                        done      = 1'b1;
                        done_lat  = (lat == '1) ? lat : lat + LAT_W'(1);
                        state_nxt = IDLE;
                        lat_nxt   = '0;
                    end else if (mon_stb) begin
                        lat_nxt = (lat == '1) ? lat : lat + LAT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    lat_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= IDLE;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) en <= 1'b1;
        else if (wr_ctrl) en <= wb_dat_o[CTRL_EN_BIT];
    end

    // CLR has priority, so a completion or abort in the same cycle is dropped.
    assign tot_sum = {1'b0, total} + (TOT_W+1)'(done_lat);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count  <= '0;
            total  <= '0;
            min_q  <= '1;
            max_q  <= '0;
            last_q <= '0;
            aborts <= '0;
        end else begin
            if (done) begin
                count  <= count + 32'd1;
                total  <= tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
                last_q <= done_lat;
                if (32'(done_lat) < min_q) min_q <= 32'(done_lat);
                if (done_lat > max_q) max_q <= done_lat;
            end
            if (abort_evt) aborts <= aborts + 32'd1;
        end
    end

`ifdef WB_LAT_PROBE_HIST_EN
    logic [31:0] hist_q;

    lat_hist u_hist (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .done  (done),
        .lat   (32'(done_lat)),
        .sel   (word[2:0]),
        .bin_q (hist_q)
    );
`endif

    always_comb begin
        rd_data = '0;
        case (word)
            REG_CTRL:  rd_data = {31'd0, en};
            REG_COUNT: rd_data = count;
            REG_TOTAL: rd_data = 32'(total);
            REG_MIN:   rd_data = min_q;
            REG_MAX:   rd_data = 32'(max_q);
            REG_LAST:  rd_data = 32'(last_q);
            REG_ABORT: rd_data = aborts;
            default:   rd_data = '0;
        endcase
`ifdef WB_LAT_PROBE_HIST_EN
        if (word[3]) rd_data = hist_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_i <= '0;
        end else begin
            wb_ack   <= access;
            wb_dat_i <= access ? rd_data : '0;
        end
    end

endmodule
